// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR coefficient LUT loader.
// Imported by the loader top and its round-robin arbiter.
package fir_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 20;
    localparam int DEF_LEN_W  = 12;
    localparam int LUT_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOST,
        ST_BURST,
        ST_BDONE
    } state_t;

    typedef enum logic {
        GR_HOST  = 1'b0,
        GR_BURST = 1'b1
    } grant_t;

endpackage

// File: rtl/fir_rr_arb2.sv
// Two-request round-robin arbiter (host vs burst) with a last-grant register.
// On a tie the requester not granted last wins; after reset the host is favoured.
module fir_rr_arb2
    import fir_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic req_host,
    input  logic req_burst,
    input  logic take,
    output logic gnt_host,
    output logic gnt_burst
);

    grant_t last;

    always_comb begin
        // NOTE: defaults first so no path leaves a grant unassigned and infers a latch.
        gnt_host  = 1'b0;
        gnt_burst = 1'b0;
        if (req_host && req_burst) begin
            gnt_host  = (last == GR_BURST);
            gnt_burst = (last == GR_HOST);
        end else begin
            gnt_host  = req_host;
            gnt_burst = req_burst;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= GR_BURST;
        end else if (take && (req_host || req_burst)) begin
            last <= gnt_burst ? GR_BURST : GR_HOST;
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Arbitrates host single-word and burst writes into the DA coefficient LUT,
// holding off writes while da_busy. Define FIR_COEF_CKSUM_EN to add the burst XOR checksum.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              h_valid,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_data,
    output logic              h_ready,
    input  logic              b_start,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [LEN_W-1:0]  b_len,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              b_done,
    input  logic              da_busy,
    output logic              lut_freeze,
`ifdef FIR_COEF_CKSUM_EN
    output logic [DATA_W-1:0] cksum,
`endif
    output logic [DATA_W-1:0] CIN,
    output logic [ADDR_W-1:0] CADDR,
    output logic              CLOAD
);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  remaining;
    logic              gnt_host;
    logic              gnt_burst;
    logic              h_accept;
    logic              b_accept;

    fir_rr_arb2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req_host  (h_valid),
        .req_burst (b_start),
        .take      (state == ST_IDLE),
        .gnt_host  (gnt_host),
        .gnt_burst (gnt_burst)
    );

    // Ready depends on da_busy this cycle so a word is never taken while the DA engine runs.
    assign h_ready  = (state == ST_HOST) && !da_busy;
    assign b_ready  = (state == ST_BURST) && !da_busy && (remaining != '0);
    assign h_accept = h_ready && h_valid;
    assign b_accept = b_ready && b_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            addr_cnt   <= '0;
            remaining  <= '0;
            CIN        <= '0;
            CADDR      <= '0;
            CLOAD      <= 1'b0;
            b_done     <= 1'b0;
            lut_freeze <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            CLOAD      <= 1'b0;
            b_done     <= (state == ST_BDONE);
            lut_freeze <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (gnt_host) begin
                        state <= ST_HOST;
                    end else if (gnt_burst) begin
                        addr_cnt  <= b_base;
                        remaining <= b_len;
                        state     <= (b_len == '0) ? ST_BDONE : ST_BURST;
                    end
                end
                ST_HOST: begin
                    if (h_accept) begin
                        CIN   <= h_data;
                        CADDR <= h_addr;
                        CLOAD <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (b_accept) begin
                        CIN       <= b_data;
                        CADDR     <= addr_cnt;
                        CLOAD     <= 1'b1;
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) state <= ST_BDONE;
                    end else if (remaining == '0) begin
                        state <= ST_BDONE;
                    end
                end
                ST_BDONE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIR_COEF_CKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cksum <= '0;
        end else if (state == ST_IDLE && !gnt_host && gnt_burst) begin
            cksum <= '0;
        end else if (state == ST_BURST && b_accept) begin
            cksum <= cksum ^ b_data;
        end
    end
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: expected LUT writes are queued at stimulus
// time and a negedge monitor pops and compares on every CLOAD.
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int LW = DEF_LEN_W;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          h_valid = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    logic          h_ready;
    logic          b_start = 1'b0;
    logic [AW-1:0] b_base = '0;
    logic [LW-1:0] b_len = '0;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          b_done;
    logic          da_busy = 1'b0;
    logic          lut_freeze;
    logic [DW-1:0] CIN;
    logic [AW-1:0] CADDR;
    logic          CLOAD;
`ifdef FIR_COEF_CKSUM_EN
    logic [DW-1:0] cksum;
    logic [DW-1:0] ck_q[$];
`endif

    fir_coef_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .h_valid    (h_valid),
        .h_addr     (h_addr),
        .h_data     (h_data),
        .h_ready    (h_ready),
        .b_start    (b_start),
        .b_base     (b_base),
        .b_len      (b_len),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .b_done     (b_done),
        .da_busy    (da_busy),
        .lut_freeze (lut_freeze),
`ifdef FIR_COEF_CKSUM_EN
        .cksum      (cksum),
`endif
        .CIN        (CIN),
        .CADDR      (CADDR),
        .CLOAD      (CLOAD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   exp_done = 0;
    int   lat;
    int   done_before;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int addr, input logic [DW-1:0] data);
        exp_q.push_back('{addr: AW'(addr % LUT_DEPTH), data: data});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: da_busy as seen on the previous edge, then compare every write.
    always @(posedge clk) busy_prev <= da_busy;

    always @(negedge clk) begin
        if (resetn) begin
            if (CLOAD) begin
                check("cload_after_busy_edge", {31'd0, busy_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_write: got CADDR=0x%0h CIN=0x%0h, expected no write", CADDR, CIN);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_caddr", 32'(CADDR), 32'(mon_e.addr));
                    check("sb_cin", 32'(CIN), 32'(mon_e.data));
                end
            end
            if (b_done) begin
                n_done++;
`ifdef FIR_COEF_CKSUM_EN
                if (ck_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cksum_unexpected_done: got cksum=0x%0h, expected no b_done", cksum);
                end else begin
                    check("cksum", 32'(cksum), 32'(ck_q.pop_front()));
                end
`endif
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int l);
        bit got = 0;
        h_valid = 1'b1;
        h_addr  = a;
        h_data  = d;
        l = 0;
        while (!got && l < 200) begin
            @(negedge clk);
            if (h_ready) got = 1;
            else begin
                @(posedge clk);
                #1;
                l++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL host_timeout: got no h_ready, expected within 200 cycles");
        end
        @(posedge clk);
        #1;
        h_valid = 1'b0;
        @(negedge clk);
        check("host_cload", {31'd0, CLOAD}, 32'd1);
        check("host_caddr", 32'(CADDR), 32'(a));
        check("host_cin", 32'(CIN), 32'(d));
        check("host_freeze", {31'd0, lut_freeze}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("host_single_strobe", {31'd0, CLOAD}, 32'd0);
    endtask

    // busy_at / abort_at: word count after which da_busy pulses for 3 cycles / resetn drops.
    task automatic burst_run(input logic [AW-1:0] base, input int len, input logic [DW-1:0] d0,
                             input int busy_at, input int abort_at);
        int i = 0;
        int t = 0;
        int busy_left = 0;
        bit acc;
        bit aborted = 0;
        b_base  = base;
        b_len   = LW'(len);
        b_start = 1'b1;
        b_valid = 1'b1;
        b_data  = d0;
        while (i < len && t < 200) begin
            @(negedge clk);
            acc = b_ready;
            @(posedge clk);
            #1;
            t++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) da_busy = 1'b0;
            end
            if (acc) begin
                i++;
                b_start = 1'b0;
                b_data  = d0 + DW'(i);
                if (i == busy_at) begin
                    da_busy   = 1'b1;
                    busy_left = 3;
                end
                if (i == abort_at) begin
                    @(negedge clk);
                    #1;
                    resetn  = 1'b0;
                    b_valid = 1'b0;
                    #1;
                    check("rst_cload", {31'd0, CLOAD}, 32'd0);
                    check("rst_caddr", 32'(CADDR), 32'd0);
                    check("rst_cin", 32'(CIN), 32'd0);
                    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
                    check("rst_freeze", {31'd0, lut_freeze}, 32'd0);
                    aborted = 1;
                    break;
                end
            end
        end
        b_valid = 1'b0;
        b_start = 1'b0;
        if (!aborted) begin
            if (t >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL burst_timeout: got %0d of %0d words, expected all", i, len);
            end else begin
                @(negedge clk);
                check("bdone_not_with_last_cload", {31'd0, b_done}, 32'd0);
                @(posedge clk);
                #1;
                @(negedge clk);
                check("bdone_after_last_cload", {31'd0, b_done}, 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        idle(2);
        @(negedge clk);
        check("reset_cload", {31'd0, CLOAD}, 32'd0);
        check("reset_caddr", 32'(CADDR), 32'd0);
        check("reset_cin", 32'(CIN), 32'd0);
        check("reset_h_ready", {31'd0, h_ready}, 32'd0);
        check("reset_b_ready", {31'd0, b_ready}, 32'd0);
        check("reset_b_done", {31'd0, b_done}, 32'd0);
        check("reset_freeze", {31'd0, lut_freeze}, 32'd0);
`ifdef FIR_COEF_CKSUM_EN
        check("reset_cksum", 32'(cksum), 32'd0);
`endif
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // Tie from reset: host first, then the wrapping burst 0x7FE..0x001 with data 1..4.
        push_wr(32'h005, 20'hABCDE);
        push_wr(32'h7FE, 20'h1);
        push_wr(32'h7FF, 20'h2);
        push_wr(32'h800, 20'h3);
        push_wr(32'h801, 20'h4);
        exp_done++;
`ifdef FIR_COEF_CKSUM_EN
        ck_q.push_back(20'h00004);
`endif
        fork
            host_write(11'h005, 20'hABCDE, lat);
            burst_run(11'h7FE, 4, 20'h1, -1, -1);
        join
        check("tie1_host_latency", 32'(lat), 32'd1);
        idle(2);

        // Lone host write leaves last-grant on the host.
        push_wr(32'h123, 20'h55555);
        host_write(11'h123, 20'h55555, lat);
        check("lone_host_latency", 32'(lat), 32'd1);
        idle(2);

        // Next tie: burst wins, host waits through BURST, BDONE and the b_done cycle.
        push_wr(32'h100, 20'h11);
        push_wr(32'h101, 20'h12);
        push_wr(32'h0AA, 20'h12345);
        exp_done++;
`ifdef FIR_COEF_CKSUM_EN
        ck_q.push_back(20'h00003);
`endif
        fork
            host_write(11'h0AA, 20'h12345, lat);
            burst_run(11'h100, 2, 20'h11, -1, -1);
        join
        check("tie2_host_stalled_latency", 32'(lat), 32'd5);
        idle(2);

        // da_busy for 3 cycles after word 2; words continue in order.
        for (int i = 0; i < 6; i++) push_wr(32'h200 + i, 20'h20 + 20'(i));
        exp_done++;
`ifdef FIR_COEF_CKSUM_EN
        ck_q.push_back(20'h00001);
`endif
        burst_run(11'h200, 6, 20'h20, 2, -1);
        idle(2);

        // Zero-length burst: no writes, b_done and lut_freeze pulse together.
        exp_done++;
`ifdef FIR_COEF_CKSUM_EN
        ck_q.push_back(20'h00000);
`endif
        b_base  = 11'h055;
        b_len   = '0;
        b_start = 1'b1;
        @(negedge clk);
        check("len0_c0_freeze", {31'd0, lut_freeze}, 32'd0);
        @(posedge clk);
        #1;
        b_start = 1'b0;
        @(negedge clk);
        check("len0_c1_bdone", {31'd0, b_done}, 32'd0);
        check("len0_c1_freeze", {31'd0, lut_freeze}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len0_c2_bdone", {31'd0, b_done}, 32'd1);
        check("len0_c2_freeze", {31'd0, lut_freeze}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len0_c3_bdone", {31'd0, b_done}, 32'd0);
        check("len0_c3_freeze", {31'd0, lut_freeze}, 32'd0);
        idle(2);

        // Reset after 2 of 8 burst words: abandoned, no b_done afterwards.
        push_wr(32'h300, 20'h30);
        push_wr(32'h301, 20'h31);
        done_before = n_done;
        burst_run(11'h300, 8, 20'h30, -1, 2);
        idle(2);
        resetn = 1'b1;
        idle(4);
        check("abort_no_bdone", 32'(n_done), 32'(done_before));

        push_wr(32'h7FF, 20'hFFFFF);
        host_write(11'h7FF, 20'hFFFFF, lat);
        check("post_reset_host_latency", 32'(lat), 32'd1);
        idle(3);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("bdone_count", 32'(n_done), 32'(exp_done));
`ifdef FIR_COEF_CKSUM_EN
        check("cksum_drained", 32'(ck_q.size()), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
